// File: rtl/pipe_hazard_ctrl_pkg.sv
// ============================================================================
// Module   : pipe_ctrl_pkg
// Brief    : Shared state encoding, EX opcodes and width defaults for the
//            pipeline stall/flush sequencer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_LSTALL = 2'd1,
    ST_FLUSH  = 2'd2,
    ST_MULTI  = 2'd3
  } state_t;

  localparam logic [3:0] OP_MUL        = 4'd1;
  localparam logic [3:0] OP_DIV        = 4'd2;
  localparam int         REG_W_DEFAULT = 4;

  function automatic logic is_multi_op(input logic [3:0] op);
    return (op == OP_MUL) || (op == OP_DIV);
  endfunction

endpackage

`default_nettype wire

// File: rtl/hazard_detect.sv
// ============================================================================
// Module   : hazard_detect
// Brief    : Combinational load-use and multi-cycle-op detection between ID/EX.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module hazard_detect
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_W = REG_W_DEFAULT
) (
  input  logic             i_id_valid,
  input  logic [REG_W-1:0] i_id_rs1,
  input  logic [REG_W-1:0] i_id_rs2,
  input  logic             i_id_uses_rs2,
  input  logic             i_ex_valid,
  input  logic [3:0]       i_ex_aluop,
  input  logic             i_ex_memToReg,
  input  logic [1:0]       i_ex_regWrite,
  input  logic [REG_W-1:0] i_ex_rd,
  output logic             o_load_use,
  output logic             o_is_multi
);

  logic w_rs1_hit;
  logic w_rs2_hit;

  // R0 is a real register here, so no zero-index exclusion.
  assign w_rs1_hit  = (i_ex_rd == i_id_rs1);
  assign w_rs2_hit  = i_id_uses_rs2 && (i_ex_rd == i_id_rs2);
  assign o_load_use = i_id_valid && i_ex_valid && i_ex_memToReg &&
                      (i_ex_regWrite != 2'b00) && (w_rs1_hit || w_rs2_hit);
  assign o_is_multi = i_ex_valid && is_multi_op(i_ex_aluop);

endmodule

`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
// ============================================================================
// Module   : pipe_hazard_ctrl
// Brief    : Stall/flush sequencer for the 4-stage pipeline. Optional cycle
//            counters enabled by macro PIPE_HAZARD_PERF_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int FLUSH_CYCLES  = 2,
  parameter int MULTI_TIMEOUT = 32,
  parameter int REG_W         = REG_W_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic             id_uses_rs2,
  input  logic             ex_valid,
  input  logic [3:0]       ex_aluop,
  input  logic             ex_memToReg,
  input  logic [1:0]       ex_regWrite,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             branch_taken,
  input  logic             multi_done,
  output logic             pc_stall,
  output logic             ifid_stall,
  output logic             idex_bubble,
  output logic             ex_hold,
  output logic             flush,
  output logic             multi_err,
  output logic [1:0]       state_o
`ifdef PIPE_HAZARD_PERF_EN
  ,
  output logic [15:0]      stall_cycles,
  output logic [15:0]      flush_cycles
`endif
);

  localparam logic [2:0] c_flush_init = 3'(FLUSH_CYCLES - 1);
  localparam logic [7:0] c_to_last    = 8'(MULTI_TIMEOUT - 1);

  state_t     r_state;
  state_t     w_state_nxt;
  logic [2:0] r_flush_cnt;
  logic [2:0] w_flush_cnt_nxt;
  logic [7:0] r_to_cnt;
  logic [7:0] w_to_cnt_nxt;
  logic       r_multi_err;
  logic       w_err_nxt;
  logic       w_load_use;
  logic       w_is_multi;

  hazard_detect #(.REG_W(REG_W)) u_hazard_detect (
    .i_id_valid    (id_valid),
    .i_id_rs1      (id_rs1),
    .i_id_rs2      (id_rs2),
    .i_id_uses_rs2 (id_uses_rs2),
    .i_ex_valid    (ex_valid),
    .i_ex_aluop    (ex_aluop),
    .i_ex_memToReg (ex_memToReg),
    .i_ex_regWrite (ex_regWrite),
    .i_ex_rd       (ex_rd),
    .o_load_use    (w_load_use),
    .o_is_multi    (w_is_multi)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state     <= ST_RUN;
      r_flush_cnt <= 3'd0;
      r_to_cnt    <= 8'd0;
      r_multi_err <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_flush_cnt <= w_flush_cnt_nxt;
      r_to_cnt    <= w_to_cnt_nxt;
      r_multi_err <= w_err_nxt;
    end
  end

  always_comb begin
    pc_stall        = 1'b0;
    ifid_stall      = 1'b0;
    idex_bubble     = 1'b0;
    ex_hold         = 1'b0;
    flush           = 1'b0;
    w_state_nxt     = r_state;
    w_flush_cnt_nxt = r_flush_cnt;
    w_to_cnt_nxt    = r_to_cnt;
    w_err_nxt       = 1'b0;
    if (!reset) begin
      flush = 1'b1;
    end else begin
      case (r_state)
        ST_RUN, ST_LSTALL: begin
          if (branch_taken) begin
            flush = 1'b1;
            if (FLUSH_CYCLES > 1) begin
              w_state_nxt     = ST_FLUSH;
              w_flush_cnt_nxt = c_flush_init;
            end else begin
              w_state_nxt = ST_RUN;
            end
          end else if (w_is_multi && (r_state == ST_RUN)) begin
            pc_stall     = 1'b1;
            ifid_stall   = 1'b1;
            ex_hold      = 1'b1;
            w_state_nxt  = ST_MULTI;
            w_to_cnt_nxt = 8'd0;
          end else if (w_load_use) begin
            pc_stall    = 1'b1;
            ifid_stall  = 1'b1;
            idex_bubble = 1'b1;
            w_state_nxt = ST_LSTALL;
          end else begin
            w_state_nxt = ST_RUN;
          end
        end
        ST_FLUSH: begin
          // Count covers the remaining flush cycles after the branch cycle.
          flush           = 1'b1;
          w_flush_cnt_nxt = r_flush_cnt - 3'd1;
          if (r_flush_cnt <= 3'd1) begin
            w_state_nxt = ST_RUN;
          end
        end
        ST_MULTI: begin
          pc_stall     = 1'b1;
          ifid_stall   = 1'b1;
          w_to_cnt_nxt = r_to_cnt + 8'd1;
          if (multi_done) begin
            w_state_nxt = ST_RUN;
          end else if (r_to_cnt == c_to_last) begin
            w_err_nxt   = 1'b1;
            w_state_nxt = ST_RUN;
          end else begin
            ex_hold = 1'b1;
          end
        end
        default: w_state_nxt = ST_RUN;
      endcase
    end
  end

  assign multi_err = r_multi_err;
  assign state_o   = r_state;

`ifdef PIPE_HAZARD_PERF_EN
  logic [15:0] r_stall_cycles;
  logic [15:0] r_flush_cycles;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_stall_cycles <= 16'd0;
      r_flush_cycles <= 16'd0;
    end else begin
      if (pc_stall && !flush && (r_stall_cycles != 16'hFFFF)) begin
        r_stall_cycles <= r_stall_cycles + 16'd1;
      end
      if (flush && (r_flush_cycles != 16'hFFFF)) begin
        r_flush_cycles <= r_flush_cycles + 16'd1;
      end
    end
  end

  assign stall_cycles = r_stall_cycles;
  assign flush_cycles = r_flush_cycles;
`endif

endmodule

`default_nettype wire
